// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: multicycle state codes, opcodes and the
// encodings of the control fields driven into the datapath.
package mips_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRtypeEx = 4'd6,
      StRtypeWb = 4'd7,
      StBeqEx   = 4'd8,
      StAddiEx  = 4'd9,
      StImmWb   = 4'd10,
      StJEx     = 4'd11,
      StOriEx   = 4'd12,
      StBneEx   = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [1:0] BRANCH_NONE = 2'b00;
   localparam logic [1:0] BRANCH_EQ   = 2'b01;
   localparam logic [1:0] BRANCH_NE   = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUSRCB_REG   = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   typedef struct packed {
      logic       pcwrite;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       iord;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] branch;
      logic [1:0] aluop;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op, input logic ext_en);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
         OP_BNE, OP_ORI:                                ok = ext_en;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// State-to-control-word decode for the multicycle control unit. Purely
// combinational so a pipelined controller can reuse it per stage.
module mc_outdec
   import mips_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.irwrite = 1'b1;
            ctrl.pcwrite = 1'b1;
            ctrl.alusrcb = ALUSRCB_FOUR;
         end
         StDecode: begin
            ctrl.alusrcb = ALUSRCB_IMMSH;
         end
         StMemAdr: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
         end
         StMemRd: begin
            ctrl.iord = 1'b1;
         end
         StMemWb: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StMemWr: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         StRtypeEx: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         StRtypeWb: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StBeqEx, StBneEx: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.branch  = (state == StBneEx) ? BRANCH_NE : BRANCH_EQ;
         end
         StAddiEx: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
         end
         StOriEx: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
            ctrl.aluop   = ALUOP_OR;
         end
         StImmWb: begin
            ctrl.regwrite = 1'b1;
         end
         StJEx: begin
            ctrl.pcsrc   = PCSRC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with optional memory-ready wait states.
module mc_maindec
   import mips_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b0,
   parameter bit EXT_EN        = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] branch,
   output logic [1:0] aluop,
   output logic       illegal,
   output logic [3:0] state
);

   state_t state_q, state_d;
   state_t dec_state;
   ctrl_t  ctrl;
   logic   ready;
   logic   fetch_ok;

   assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch: begin
            if (ready) state_d = StDecode;
         end
         StDecode: begin
            case (op)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_RTYPE:     state_d = StRtypeEx;
               OP_BEQ:       state_d = StBeqEx;
               OP_BNE:       state_d = EXT_EN ? StBneEx : StFetch;
               OP_ADDI:      state_d = StAddiEx;
               OP_ORI:       state_d = EXT_EN ? StOriEx : StFetch;
               OP_J:         state_d = StJEx;
               default:      state_d = StFetch;
            endcase
         end
         StMemAdr:  state_d = (op == OP_LW) ? StMemRd : StMemWr;
         StMemRd: begin
            if (ready) state_d = StMemWb;
         end
         StMemWr: begin
            if (ready) state_d = StFetch;
         end
         StRtypeEx: state_d = StRtypeWb;
         StAddiEx:  state_d = StImmWb;
         StOriEx:   state_d = StImmWb;
         // Writeback/branch/jump states and the two unused codes all return to fetch.
         default:   state_d = StFetch;
      endcase
   end

   // During reset the datapath sees fetch controls with every write suppressed.
   assign dec_state = reset ? StFetch : state_q;

   mc_outdec u_outdec (
      .state (dec_state),
      .ctrl  (ctrl)
   );

   assign fetch_ok = (dec_state != StFetch) | ready;

   assign pcwrite  = ~reset & ctrl.pcwrite & fetch_ok;
   assign irwrite  = ~reset & ctrl.irwrite & fetch_ok;
   assign memwrite = ~reset & ctrl.memwrite;
   assign regwrite = ~reset & ctrl.regwrite;
   assign iord     = ctrl.iord;
   assign regdst   = ctrl.regdst;
   assign memtoreg = ctrl.memtoreg;
   assign alusrca  = ctrl.alusrca;
   assign alusrcb  = ctrl.alusrcb;
   assign pcsrc    = ctrl.pcsrc;
   assign branch   = ctrl.branch;
   assign aluop    = ctrl.aluop;

   assign illegal  = ~reset & (state_q == StDecode) & ~op_legal(op, EXT_EN);
   assign state    = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: two instances (handshake+ext, and no-handshake/no-ext)
// checked every cycle against a sequence-level model, plus literal pins.
module tb_mc_maindec;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;

   logic a_pcwrite, a_irwrite, a_memwrite, a_regwrite, a_iord, a_regdst, a_memtoreg, a_alusrca;
   logic [1:0] a_alusrcb, a_pcsrc, a_branch, a_aluop;
   logic a_illegal;
   logic [3:0] a_state;
   logic b_pcwrite, b_irwrite, b_memwrite, b_regwrite, b_iord, b_regdst, b_memtoreg, b_alusrca;
   logic [1:0] b_alusrcb, b_pcsrc, b_branch, b_aluop;
   logic b_illegal;
   logic [3:0] b_state;

   logic [15:0] a_ctrl, b_ctrl;
   assign a_ctrl = {a_pcwrite, a_irwrite, a_memwrite, a_regwrite, a_iord, a_regdst, a_memtoreg,
                    a_alusrca, a_alusrcb, a_pcsrc, a_branch, a_aluop};
   assign b_ctrl = {b_pcwrite, b_irwrite, b_memwrite, b_regwrite, b_iord, b_regdst, b_memtoreg,
                    b_alusrca, b_alusrcb, b_pcsrc, b_branch, b_aluop};

   mc_maindec #(.MEM_HANDSHAKE(1'b1), .EXT_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .pcwrite(a_pcwrite), .irwrite(a_irwrite), .memwrite(a_memwrite), .regwrite(a_regwrite),
      .iord(a_iord), .regdst(a_regdst), .memtoreg(a_memtoreg), .alusrca(a_alusrca),
      .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .branch(a_branch), .aluop(a_aluop),
      .illegal(a_illegal), .state(a_state)
   );

   mc_maindec #(.MEM_HANDSHAKE(1'b0), .EXT_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .pcwrite(b_pcwrite), .irwrite(b_irwrite), .memwrite(b_memwrite), .regwrite(b_regwrite),
      .iord(b_iord), .regdst(b_regdst), .memtoreg(b_memtoreg), .alusrca(b_alusrca),
      .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .branch(b_branch), .aluop(b_aluop),
      .illegal(b_illegal), .state(b_state)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // ---------------- model: per instance current state + planned path ----------------
   int m_st[2];
   int m_pl[2][4];
   int m_n[2];

   function automatic bit legal(input logic [5:0] o, input bit ext);
      if (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 ||
          o == 6'b001000 || o == 6'b000010) return 1'b1;
      if (o == 6'b000101 || o == 6'b001101) return ext;
      return 1'b0;
   endfunction

   task automatic push(input int i, input int s);
      m_pl[i][m_n[i]] = s;
      m_n[i]++;
   endtask

   task automatic mstep(input int i);
      bit hs, ext, rdy;
      hs  = (i == 0);
      ext = (i == 0);
      rdy = !hs || mem_ready;
      if (reset) begin
         m_st[i] = 0;
         m_n[i]  = 0;
      end else if ((m_st[i] == 0 || m_st[i] == 3 || m_st[i] == 5) && !rdy) begin
         m_st[i] = m_st[i];
      end else begin
         if (m_st[i] == 1) begin
            m_n[i] = 0;
            case (op)
               6'b100011, 6'b101011: push(i, 2);
               6'b000000: begin push(i, 6); push(i, 7); end
               6'b000100: push(i, 8);
               6'b000101: if (ext) push(i, 13);
               6'b001000: begin push(i, 9); push(i, 10); end
               6'b001101: if (ext) begin push(i, 12); push(i, 10); end
               6'b000010: push(i, 11);
               default: ;
            endcase
         end else if (m_st[i] == 2) begin
            m_n[i] = 0;
            if (op == 6'b100011) begin push(i, 3); push(i, 4); end
            else push(i, 5);
         end
         if (m_n[i] > 0) begin
            m_st[i] = m_pl[i][0];
            for (int k = 0; k < 3; k++) m_pl[i][k] = m_pl[i][k+1];
            m_n[i]--;
         end else begin
            m_st[i] = (m_st[i] == 0) ? 1 : 0;
         end
      end
   endtask

   initial begin
      m_st[0] = 0; m_st[1] = 0; m_n[0] = 0; m_n[1] = 0;
   end

   always @(posedge clk) begin
      mstep(0);
      mstep(1);
   end

   // Control word bit order: pcw irw mw rw iord regdst m2r asa asb[2] pcsrc[2] br[2] aluop[2]
   function automatic logic [15:0] exp_ctrl(input int st, input bit rst, input bit fok);
      logic pcw, irw, mw, rw, io, rd, m2r, asa;
      logic [1:0] asb, pcs, br, aop;
      int s;
      {pcw, irw, mw, rw, io, rd, m2r, asa} = 8'b0;
      asb = 2'b00; pcs = 2'b00; br = 2'b00; aop = 2'b00;
      s = rst ? 0 : st;
      case (s)
         0:  begin pcw = fok; irw = fok; asb = 2'b01; end
         1:  asb = 2'b11;
         2:  begin asa = 1'b1; asb = 2'b10; end
         3:  io = 1'b1;
         4:  begin m2r = 1'b1; rw = 1'b1; end
         5:  begin io = 1'b1; mw = 1'b1; end
         6:  begin asa = 1'b1; aop = 2'b10; end
         7:  begin rd = 1'b1; rw = 1'b1; end
         8:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 2'b01; end
         13: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 2'b10; end
         9:  begin asa = 1'b1; asb = 2'b10; end
         12: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
         10: rw = 1'b1;
         11: begin pcs = 2'b10; pcw = 1'b1; end
         default: ;
      endcase
      if (rst) {pcw, irw, mw, rw} = 4'b0;
      return {pcw, irw, mw, rw, io, rd, m2r, asa, asb, pcs, br, aop};
   endfunction

   // ---------------- per-cycle compare + trace capture ----------------
   logic [3:0]  tr_sa[$], tr_ma[$], tr_sb[$], tr_mb[$];
   logic [15:0] tr_ca[$], tr_cb[$];
   logic        tr_ia[$], tr_ib[$];

   always @(negedge clk) begin
      if (chk_en) begin
         pin("a state", a_state, m_st[0]);
         pin("a ctrl", a_ctrl, exp_ctrl(m_st[0], reset, mem_ready));
         pin("a illegal", a_illegal, !reset && m_st[0] == 1 && !legal(op, 1'b1));
         pin("b state", b_state, m_st[1]);
         pin("b ctrl", b_ctrl, exp_ctrl(m_st[1], reset, 1'b1));
         pin("b illegal", b_illegal, !reset && m_st[1] == 1 && !legal(op, 1'b0));
         tr_sa.push_back(a_state);  tr_ma.push_back(4'(m_st[0]));
         tr_sb.push_back(b_state);  tr_mb.push_back(4'(m_st[1]));
         tr_ca.push_back(a_ctrl);   tr_cb.push_back(b_ctrl);
         tr_ia.push_back(a_illegal); tr_ib.push_back(b_illegal);
      end
   end

   task automatic clear_traces();
      tr_sa.delete(); tr_ma.delete(); tr_sb.delete(); tr_mb.delete();
      tr_ca.delete(); tr_cb.delete(); tr_ia.delete(); tr_ib.delete();
   endtask

   // One cycle: drive mem_ready, let the negedge compare run, land at posedge+1.
   task automatic cyc(input bit mr);
      mem_ready = mr;
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic start_test(input logic [5:0] o);
      reset = 1'b1;
      cyc(1'b1);
      reset = 1'b0;
      op = o;
      clear_traces();
   endtask

   // Expected state sequences as nibble strings, first state in the top nibble.
   task automatic chk_trace(input string name, input logic [63:0] ea, input logic [63:0] eb,
                            input int n);
      pin({name, " trace len"}, tr_sa.size(), n);
      for (int k = 0; k < n && k < tr_sa.size(); k++) begin
         pin({name, " a state seq"}, tr_sa[k], ea[4*(n-1-k) +: 4]);
         pin({name, " a model seq"}, tr_ma[k], ea[4*(n-1-k) +: 4]);
         pin({name, " b state seq"}, tr_sb[k], eb[4*(n-1-k) +: 4]);
         pin({name, " b model seq"}, tr_mb[k], eb[4*(n-1-k) +: 4]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      op = 6'b000000;
      mem_ready = 1'b1;

      // Reset held two edges, then R-type.
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      cyc(1'b1);
      reset = 1'b0;
      repeat (5) cyc(1'b1);
      chk_trace("rtype", 64'h001670, 64'h001670, 6);
      pin("reset enables", tr_ca[0][15:12], 4'b0000);
      pin("fetch pc/ir write", tr_ca[1][15:14], 2'b11);
      pin("rtypeex regwrite", tr_ca[3][12], 1'b0);
      pin("rtypewb regdst/regwrite", {tr_ca[4][10], tr_ca[4][12]}, 2'b11);

      // LW with two MEMRD wait cycles (only instance a waits).
      start_test(6'b100011);
      cyc(1); cyc(1); cyc(1); cyc(0); cyc(0); cyc(1); cyc(1); cyc(1);
      chk_trace("lw", 64'h01233340, 64'h01234012, 8);
      pin("lw memrd iord", {tr_ca[3][11], tr_ca[4][11], tr_ca[5][11]}, 3'b111);
      pin("lw memwb memtoreg/regwrite", {tr_ca[6][9], tr_ca[6][12]}, 2'b11);
      pin("lw memrd regwrite", tr_ca[5][12], 1'b0);

      // BNE: legal on a, illegal on b.
      start_test(6'b000101);
      repeat (4) cyc(1);
      chk_trace("bne", 64'h01D0, 64'h0101, 4);
      pin("bne branch/pcsrc/aluop", {tr_ca[2][3:2], tr_ca[2][5:4], tr_ca[2][1:0]}, 6'b10_01_01);
      pin("bne b illegal pulse", {tr_ib[0], tr_ib[1], tr_ib[2]}, 3'b010);
      pin("bne b decode enables", tr_cb[1][15:12], 4'b0000);

      // ORI.
      start_test(6'b001101);
      repeat (5) cyc(1);
      chk_trace("ori", 64'h01CA0, 64'h01010, 5);
      pin("oriex aluop/alusrcb", {tr_ca[2][1:0], tr_ca[2][7:6]}, 4'b11_10);
      pin("ori immwb regwrite/regdst", {tr_ca[3][12], tr_ca[3][10]}, 2'b10);

      // J.
      start_test(6'b000010);
      repeat (4) cyc(1);
      chk_trace("j", 64'h01B0, 64'h01B0, 4);
      pin("jex pcsrc/pcwrite", {tr_ca[2][5:4], tr_ca[2][15]}, 3'b10_1);

      // Unsupported opcode.
      start_test(6'b111111);
      repeat (5) cyc(1);
      chk_trace("bad op", 64'h01010, 64'h01010, 5);
      pin("bad op illegal pulse", {tr_ia[0], tr_ia[1], tr_ia[2]}, 3'b010);
      pin("bad op decode enables", tr_ca[1][15:12], 4'b0000);

      // SW, reset while held in MEMWR.
      start_test(6'b101011);
      cyc(1); cyc(1); cyc(1); cyc(0);
      reset = 1'b1;
      cyc(0);
      reset = 1'b0;
      cyc(1);
      chk_trace("sw reset", 64'h012550, 64'h012500, 6);
      pin("memwr memwrite", tr_ca[3][13], 1'b1);
      pin("reset in memwr enables", tr_ca[4][15:12], 4'b0000);

      // ADDI with one fetch wait cycle.
      start_test(6'b001000);
      cyc(0);
      repeat (5) cyc(1);
      chk_trace("addi", 64'h0019A0, 64'h019A01, 6);
      pin("fetch wait pcwrite", tr_ca[0][15:14], 2'b00);
      pin("fetch ready pcwrite", tr_ca[1][15:14], 2'b11);
      pin("b fetch ignores ready", tr_cb[0][15:14], 2'b11);

      // BEQ.
      start_test(6'b000100);
      repeat (4) cyc(1);
      chk_trace("beq", 64'h0180, 64'h0180, 4);
      pin("beqex branch", tr_ca[2][3:2], 2'b01);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main control unit for the MIPS core. It replaces the single-cycle combinational opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several clock cycles. It drives the shared-memory multicycle datapath: PC, instruction register, register file, ALU source muxes and the ALU decoder (via `aluop`). It supports an optional memory-ready handshake and a parameter that switches the extended opcodes on or off.

## Interface
- `MEM_HANDSHAKE`, default 0: when 1, memory-access states hold until `mem_ready`; when 0, `mem_ready` is ignored and each access takes one cycle.
- `EXT_EN`, default 1: when 1, BNE (000101) and ORI (001101) are legal; when 0, they decode as illegal.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge of `clk`.
- `op`  in  6  opcode from the instruction register; valid from DECODE onward.
- `mem_ready`  in  1  memory completed the current access (used only if `MEM_HANDSHAKE`=1).
- `pcwrite`, `irwrite`, `memwrite`, `regwrite`  out  1 each  write enables.
- `iord`, `regdst`, `memtoreg`, `alusrca`  out  1 each  datapath mux selects.
- `alusrcb`  out  2  ALU B select: 00 reg, 01 constant 4, 10 immediate, 11 immediate<<2.
- `pcsrc`  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `branch`  out  2  branch kind: 00 none, 01 BEQ, 10 BNE. Datapath PC enable = `pcwrite` | (`branch`==01 & zero) | (`branch`==10 & ~zero).
- `aluop`  out  2  to the ALU decoder: 00 add, 01 sub, 10 funct, 11 or.
- `illegal`  out  1  one-cycle pulse in DECODE when `op` is unsupported.
- `state`  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IMMWB 10, JEX 11, ORIEX 12, BNEEX 13. Codes 14 and 15 are unused and go to FETCH.
- Output assertions per state (anything not listed is 0):
  - FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `aluop`=10.
  - RTYPEWB: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=01.
  - BNEEX: same as BEQEX, but `branch`=10.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ORIEX: `alusrca`=1, `alusrcb`=10, `aluop`=11.
  - IMMWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE branches on `op`:
    - 100011 or 101011 → MEMADR.
    - 000000 → RTYPEEX.
    - 000100 → BEQEX.
    - 000101 → BNEEX.
    - 001000 → ADDIEX.
    - 001101 → ORIEX.
    - 000010 → JEX.
    - anything else → FETCH with `illegal`=1.
  - MEMADR→MEMRD if `op`=100011, otherwise MEMWR.
  - MEMRD→MEMWB; RTYPEEX→RTYPEWB; ADDIEX and ORIEX→IMMWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, IMMWB and JEX all → FETCH.
- Handshake (`MEM_HANDSHAKE`=1):
  - FETCH, MEMRD and MEMWR hold while `mem_ready`=0.
  - In FETCH, `pcwrite` and `irwrite` are asserted only in the cycle where `mem_ready`=1.
  - `memwrite` stays asserted for the whole MEMWR stay; the memory must treat repeated writes of the same data as idempotent.
- Outputs are decoded from the state register only (Moore). `illegal` is the single exception: it is combinational from the state and `op`.

## Timing
- Reset: `state` becomes FETCH on the first edge with `reset`=1. While `reset`=1, `pcwrite`, `irwrite`, `memwrite`, `regwrite` and `illegal` are forced to 0; the other outputs show their FETCH values.
- Reset mid-instruction: the next edge goes to FETCH unconditionally; no write enable is asserted in the reset cycle.
- Latency with no wait states:
  - LW: 5 cycles.
  - SW, R-type, ADDI, ORI: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each wait cycle with `mem_ready`=0 adds one cycle to the state it occurs in.
- `op` is sampled in DECODE and MEMADR only; changes in other states have no effect.

## Structure
- Shared package `mips_pkg`: state encodings, opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_ADDI`, `OP_ORI`, `OP_J`), plus the `aluop`, `branch` and `pcsrc` encodings.
- Split into two parts inside `mc_maindec`: a next-state process and a state register. The output decode is a sub-module `mc_outdec`, mapping state to the control word, so it can be reused by a future pipelined control unit.

## Test plan
- Reset held 2 cycles, then released with `op`=000000: `state` goes 0→1→6→7→0. `regdst`=1 and `regwrite`=1 only in state 7. All write enables are 0 during reset.
- LW, `MEM_HANDSHAKE`=1, `mem_ready` low 2 cycles in MEMRD: the sequence is 0,1,2,3,3,3,4,0. `iord`=1 throughout state 3; `memtoreg`=1 and `regwrite`=1 only in state 4.
- BNE with `EXT_EN`=1: state 13 shows `branch`=10, `aluop`=01, `pcsrc`=01. With `EXT_EN`=0, DECODE pulses `illegal`=1 and the next state is 0.
- ORI: state 12 shows `aluop`=11, `alusrcb`=10; then IMMWB with `regwrite`=1, `regdst`=0.
- J: state 11 shows `pcsrc`=10, `pcwrite`=1, then FETCH; total 3 cycles.
- `op`=111111: `illegal` is high for exactly one cycle, no write enable is asserted, and the machine returns to FETCH. `reset` asserted while in MEMWR: the next state is 0 and `memwrite` is 0 in the reset cycle.
